mod_accumulator_mc: RTL and testbench
=====================================

# mod_accumulator_mc

Multi-channel modular accumulator with a streaming valid/ready interface. It holds `CHANNELS` independent residues mod `iQ`. Each accepted beat adds or subtracts `iData` into the selected channel. A beat flagged last emits the final residue and clears that channel. It sits between modular-multiplier outputs and downstream NTT/RNS consumers, replacing single-channel accumulators where several interleaved sums share one datapath.

## Interface
- `BITWIDTH`, 32: width of data, modulus and residues.
- `CHANNELS`, 4: number of independent accumulators; must be ≥ 2.
- `CH_W`, `$clog2(CHANNELS)`: channel index width (derived localparam).

Ports:
- `iClk`  in  1  clock.
- `iRstN`  in  1  reset, asynchronous, active-low.
- `iClr`  in  1  synchronous clear of all channels and of the output register.
- `iQ`  in  BITWIDTH  modulus; held stable while any channel is nonzero.
- `iValid`  in  1  input beat valid.
- `oReady`  out  1  input beat accepted when `iValid & oReady`.
- `iCh`  in  CH_W  target channel.
- `iData`  in  BITWIDTH  operand; caller guarantees `iData < iQ`.
- `iSub`  in  1  0 = add, 1 = subtract, mod `iQ`.
- `iLast`  in  1  final beat of the channel's sum: emit the result and clear the channel.
- `oValid`  out  1  result valid.
- `iReady`  in  1  downstream accepts the result when `oValid & iReady`.
- `oCh`  out  CH_W  channel of the emitted result.
- `oData`  out  BITWIDTH  emitted residue.

## Operation
- Bank `acc[0..CHANNELS-1]`, each `BITWIDTH` bits, invariant `acc < iQ`.
- Add mode: `s = acc[iCh] + iData`, computed at BITWIDTH+1 bits. Result `r = (s < iQ) ? s : s - iQ`.
- Subtract mode: `d = acc[iCh] - iData`, computed at BITWIDTH+1 bits. Result `r = d[BITWIDTH] ? d + iQ : d`, truncated to BITWIDTH.
- Accept without `iLast`: `acc[iCh] <= r`.
- Accept with `iLast`: `acc[iCh] <= 0`, `oData <= r`, `oCh <= iCh`, `oValid <= 1`.
- `oReady = (~oValid | iReady) & ~iClr`. This is the only combinational path and it has no dependence on `iValid`.
- Output register: `oValid` clears on `oValid & iReady` unless a new last-beat loads in the same cycle, in which case it stays 1 with new data.
- `iClr` (priority over everything except reset): all `acc` ← 0 and `oValid` ← 0. No beat is accepted that cycle; a pending result is dropped.
- Reset: all `acc` = 0, `oValid` = 0, `oData` = 0, `oCh` = 0.
- Reset mid-sum: all partial sums are lost. No output is produced.
- Operands with `iData ≥ iQ` are outside the contract; the result is undefined but must not produce X.

## Timing
- Throughput: one beat per cycle while `oReady = 1`.
- Latency: an accepted beat updates `acc` at the next edge. Back-to-back beats to the same channel see the updated value, with no stall or hazard.
- Last-beat latency: `oValid` rises 1 cycle after acceptance.
- Backpressure: with `oValid = 1` and `iReady = 0`, `oReady = 0`. All beats, last or not, stall. `oData`/`oCh` stay stable until taken.
- Same-cycle take and refill: `oValid` stays 1 and the new result replaces the old one with no bubble.
- Wrap-around: an add with `s = iQ` exactly yields 0. A subtract with `acc = iData` yields 0.

## Structure
- Shared package/header `mod_acc_defs`:
  - `CLOG2` helper.
  - Mode encoding `MODE_ADD = 0`, `MODE_SUB = 1`.
  - Default `BITWIDTH`.
- Sub-module `mod_addsub`: purely combinational single-conditional-correction modular add/sub (`a`, `b`, `q`, `sub` → `r`), reusable by other modular blocks.
- Top level holds:
  - the register bank, implemented as registers rather than RAM, with an asynchronous reset requirement;
  - the channel read mux;
  - the output register and handshake logic.

## Test plan
- Add with `iQ = 17`, ch 0: beats 5, 9, 7 (last) → `oValid` one cycle after the last accept, `oData = 4`, `oCh = 0`; `acc[0] = 0` afterwards.
- Subtract/wrap with `iQ = 17`, ch 2: add 3, then sub 5 (last) → `oData = 15`. Separately, add 8 then add 9 (last) → `oData = 0`.
- Interleave with `iQ = 97`, alternating ch 1/ch 3 every cycle: ch 1 adds 50, 50, 50 (last) → 53; ch 3 adds 96, 1 (last) → 0. Results arrive in last-beat order, each tagged with the correct `oCh`.
- Backpressure: hold `iReady = 0` after a result → `oReady = 0`, `oData` stable for 5 cycles, and no accumulator changes. Then release `iReady` while a last-beat is waiting → the old result is taken and the new one loads the same cycle with no bubble.
- Clear/reset: issue `iClr` while `oValid = 1` and channels are nonzero → `oValid = 0` and `oReady = 0` that cycle, and subsequent sums start from 0. Deassert `iRstN` asynchronously mid-stream → all outputs are 0 immediately.
- Max width with `BITWIDTH = 32`, `iQ = 2^32 - 5`: add `iQ - 1` twice → `acc = iQ - 2`, with no overflow from the 33-bit intermediate.

Source files
------------

// File: rtl/mod_accumulator_mc_pkg.sv
// Shared definitions for the modular accumulator slice: default width,
// add/sub mode encoding and a constant clog2 helper.
package mod_acc_defs;

   localparam int   DEF_BITWIDTH = 32;
   localparam logic MODE_ADD     = 1'b0;
   localparam logic MODE_SUB     = 1'b1;

   function automatic int CLOG2(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/mod_accumulator_mc_addsub.sv
// Combinational modular add/subtract with a single conditional correction.
// Requires a < q and b < q for a reduced result.
module mod_addsub
   import mod_acc_defs::*;
#(
   parameter int BITWIDTH = DEF_BITWIDTH
) (
   input  logic [BITWIDTH-1:0] a,
   input  logic [BITWIDTH-1:0] b,
   input  logic [BITWIDTH-1:0] q,
   input  logic                sub,
   output logic [BITWIDTH-1:0] r
);

   logic [BITWIDTH:0] sumWide;
   logic [BITWIDTH:0] difWide;
   logic [BITWIDTH:0] sumCorr;
   logic [BITWIDTH:0] difCorr;

   // One extra bit keeps the carry/borrow so no intermediate overflows.
   always_comb begin
      sumWide = {1'b0, a} + {1'b0, b};
      difWide = {1'b0, a} - {1'b0, b};
      sumCorr = sumWide - {1'b0, q};
      difCorr = difWide + {1'b0, q};
      r       = '0;
      if (sub == MODE_SUB) begin
         r = difWide[BITWIDTH] ? difCorr[BITWIDTH-1:0] : difWide[BITWIDTH-1:0];
      end else begin
         r = (sumWide < {1'b0, q}) ? sumWide[BITWIDTH-1:0] : sumCorr[BITWIDTH-1:0];
      end
   end

endmodule

// File: rtl/mod_accumulator_mc.sv
// Multi-channel modular accumulator: per-channel residues mod iQ, fed by a
// valid/ready beat stream; a last beat emits the residue and clears its channel.
module mod_accumulator_mc
   import mod_acc_defs::*;
#(
   parameter  int BITWIDTH = DEF_BITWIDTH,
   parameter  int CHANNELS = 4,
   localparam int CH_W     = CLOG2(CHANNELS)
) (
   input  logic                iClk,
   input  logic                iRstN,
   input  logic                iClr,
   input  logic [BITWIDTH-1:0] iQ,
   input  logic                iValid,
   output logic                oReady,
   input  logic [CH_W-1:0]     iCh,
   input  logic [BITWIDTH-1:0] iData,
   input  logic                iSub,
   input  logic                iLast,
   output logic                oValid,
   input  logic                iReady,
   output logic [CH_W-1:0]     oCh,
   output logic [BITWIDTH-1:0] oData
);

   logic [BITWIDTH-1:0] acc [CHANNELS];
   logic [BITWIDTH-1:0] accSel;
   logic [BITWIDTH-1:0] result;
   logic                accept;

   // Ready never looks at iValid, so upstream can wait on it freely.
   assign oReady = (~oValid | iReady) & ~iClr;
   assign accept = iValid & oReady;

   always_comb begin
      accSel = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (iCh == CH_W'(i)) accSel = acc[i];
      end
   end

   mod_addsub #(
      .BITWIDTH(BITWIDTH)
   ) uAddSub (
      .a  (accSel),
      .b  (iData),
      .q  (iQ),
      .sub(iSub),
      .r  (result)
   );

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
      end else if (iClr) begin
         for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
      end else if (accept) begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (iCh == CH_W'(i)) acc[i] <= iLast ? '0 : result;
         end
      end
   end

   // A take and a new last-beat in the same cycle keep oValid high.
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         oValid <= 1'b0;
         oData  <= '0;
         oCh    <= '0;
      end else if (iClr) begin
         oValid <= 1'b0;
      end else begin
         if (oValid && iReady) oValid <= 1'b0;
         if (accept && iLast) begin
            oValid <= 1'b1;
            oData  <= result;
            oCh    <= iCh;
         end
      end
   end

endmodule

// File: tb/tb_mod_accumulator_mc.sv
// Self-checking bench for mod_accumulator_mc: directed scenarios with literal
// expectations plus randomized traffic against a behavioural residue model.
module tb_mod_accumulator_mc;

   localparam int BW = 32;
   localparam int CH = 4;
   localparam int CW = 2;

   logic          iClk = 1'b0;
   logic          iRstN = 1'b0;
   logic          iClr = 1'b0;
   logic [BW-1:0] iQ = 32'd17;
   logic          iValid = 1'b0;
   logic          oReady;
   logic [CW-1:0] iCh = '0;
   logic [BW-1:0] iData = '0;
   logic          iSub = 1'b0;
   logic          iLast = 1'b0;
   logic          oValid;
   logic          iReady = 1'b0;
   logic [CW-1:0] oCh;
   logic [BW-1:0] oData;

   int checks = 0;
   int failures = 0;

   longint unsigned mAcc [CH];
   bit              mValid;
   longint unsigned mData;
   int              mCh;

   mod_accumulator_mc #(.BITWIDTH(BW), .CHANNELS(CH)) dut (
      .iClk(iClk), .iRstN(iRstN), .iClr(iClr), .iQ(iQ),
      .iValid(iValid), .oReady(oReady), .iCh(iCh), .iData(iData),
      .iSub(iSub), .iLast(iLast), .oValid(oValid), .iReady(iReady),
      .oCh(oCh), .oData(oData)
   );

   always #5 iClk = ~iClk;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < CH; i++) mAcc[i] = 0;
      mValid = 0;
      mData  = 0;
      mCh    = 0;
   endtask

   // Residue arithmetic from the definition: (a +/- d) mod q.
   task automatic modelEdge(input bit v, input int ch, input longint unsigned d,
                            input bit sub, input bit last, input bit rdy, input bit clr);
      longint unsigned q, r;
      bit acc;
      q = iQ;
      if (clr) begin
         for (int i = 0; i < CH; i++) mAcc[i] = 0;
         mValid = 0;
         return;
      end
      acc = v && (!mValid || rdy);
      if (mValid && rdy) mValid = 0;
      if (acc) begin
         r = sub ? (mAcc[ch] + q - d) % q : (mAcc[ch] + d) % q;
         if (last) begin
            mAcc[ch] = 0;
            mData    = r;
            mCh      = ch;
            mValid   = 1;
         end else begin
            mAcc[ch] = r;
         end
      end
   endtask

   // Called one time unit after a rising edge; returns one unit after the next.
   task automatic step(input bit v, input int ch, input logic [BW-1:0] d,
                       input bit sub, input bit last, input bit rdy, input bit clr);
      iValid = v; iCh = CW'(ch); iData = d; iSub = sub; iLast = last;
      iReady = rdy; iClr = clr;
      #1 chk("oReady", {63'd0, oReady}, {63'd0, ((!mValid || rdy) && !clr)});
      @(posedge iClk);
      modelEdge(v, ch, d, sub, last, rdy, clr);
      #1;
      chk("oValid", {63'd0, oValid}, {63'd0, mValid});
      if (mValid) begin
         chk("oData", {32'd0, oData}, mData);
         chk("oCh", {62'd0, oCh}, 64'(mCh));
      end
   endtask

   task automatic beat(input int ch, input logic [BW-1:0] d, input bit sub, input bit last);
      step(1'b1, ch, d, sub, last, 1'b1, 1'b0);
   endtask

   task automatic idle();
      step(1'b0, 0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   logic [BW-1:0] q;
   logic [BW-1:0] maxQ;

   initial begin
      modelReset();
      #2;
      chk("rst_oValid", {63'd0, oValid}, 64'd0);
      chk("rst_oData", {32'd0, oData}, 64'd0);
      chk("rst_oCh", {62'd0, oCh}, 64'd0);
      repeat (2) @(posedge iClk);
      #1 iRstN = 1'b1;

      // Plain add on channel 0: 5 + 9 + 7 = 21 = 4 mod 17.
      beat(0, 5, 0, 0);
      beat(0, 9, 0, 0);
      beat(0, 7, 0, 1);
      chk("add_lit_data", {32'd0, oData}, 64'd4);
      chk("add_lit_ch", {62'd0, oCh}, 64'd0);
      beat(0, 3, 0, 1);
      chk("add_cleared_lit", {32'd0, oData}, 64'd3);

      // Subtract wrap and exact-modulus wrap.
      beat(2, 3, 0, 0);
      beat(2, 5, 1, 1);
      chk("sub_wrap_lit", {32'd0, oData}, 64'd15);
      beat(2, 8, 0, 0);
      beat(2, 9, 0, 1);
      chk("add_eq_q_lit", {32'd0, oData}, 64'd0);
      beat(1, 4, 0, 0);
      beat(1, 4, 1, 1);
      chk("sub_eq_lit", {32'd0, oData}, 64'd0);

      // Interleaved channels with modulus 97.
      step(1'b0, 0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
      iQ = 32'd97;
      beat(1, 50, 0, 0);
      beat(3, 96, 0, 0);
      beat(1, 50, 0, 0);
      beat(3, 1, 0, 1);
      chk("il_ch3_data", {32'd0, oData}, 64'd0);
      chk("il_ch3_ch", {62'd0, oCh}, 64'd3);
      beat(1, 50, 0, 1);
      chk("il_ch1_data", {32'd0, oData}, 64'd53);
      chk("il_ch1_ch", {62'd0, oCh}, 64'd1);

      // Backpressure: beats stall, output holds, then take+refill with no bubble.
      beat(0, 4, 0, 1);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 0, 1, 1'b0, 1'b0, 1'b0, 1'b0);
         chk("bp_hold_data", {32'd0, oData}, 64'd4);
      end
      beat(0, 6, 0, 1);
      chk("bp_refill_valid", {63'd0, oValid}, 64'd1);
      chk("bp_refill_data", {32'd0, oData}, 64'd6);

      // Clear with a pending result and nonzero channel.
      beat(1, 10, 0, 0);
      beat(2, 3, 0, 1);
      step(1'b1, 1, 5, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("clr_oValid", {63'd0, oValid}, 64'd0);
      beat(1, 2, 0, 1);
      chk("clr_fresh_lit", {32'd0, oData}, 64'd2);

      // Asynchronous reset mid-stream.
      beat(3, 20, 0, 0);
      beat(0, 5, 0, 1);
      #2 iRstN = 1'b0;
      #1;
      chk("arst_oValid", {63'd0, oValid}, 64'd0);
      chk("arst_oData", {32'd0, oData}, 64'd0);
      chk("arst_oCh", {62'd0, oCh}, 64'd0);
      modelReset();
      @(posedge iClk);
      #1 iRstN = 1'b1;
      beat(3, 7, 0, 1);
      chk("arst_fresh_lit", {32'd0, oData}, 64'd7);

      // Full width: q = 2^32-5, (q-1)+(q-1) = q-2 with no 33-bit overflow.
      step(1'b0, 0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
      maxQ = 32'hFFFF_FFFB;
      iQ = maxQ;
      beat(0, maxQ - 1, 0, 0);
      beat(0, maxQ - 1, 0, 0);
      beat(0, 0, 0, 1);
      chk("max_lit", {32'd0, oData}, 64'hFFFF_FFF9);

      // Randomized traffic, periodic clear and new modulus.
      for (int blk = 0; blk < 8; blk++) begin
         step(1'b0, 0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
         q = (blk % 2 == 0) ? 32'($urandom_range(20, 2)) : ($urandom | 32'h8000_0000);
         iQ = q;
         for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(3, 0) != 0), int'($urandom_range(CH - 1, 0)),
                 $urandom % q, 1'($urandom_range(1, 0)),
                 ($urandom_range(3, 0) == 0), ($urandom_range(3, 0) != 0),
                 ($urandom_range(99, 0) == 0));
         end
      end
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
